// File: rtl/frame_filter_engine.sv
// 3x3 neighbourhood filter: fetches an edge-replicated window per pixel and writes one result per pixel in raster order.
// Optional BINARIZE_EN adds a thresh port that maps each result to all-ones or zero.
module frame_filter_engine #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
`ifdef BINARIZE_EN
    input  logic [PIX_W-1:0]  thresh,
`endif
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
);
    // state   | meaning
    // IDLE    | after reset, waiting for start
    // FETCH   | issuing the nine window reads, one per cycle
    // WAIT    | RD_LAT cycles draining the last reads
    // COMPUTE | kernel evaluated and registered
    // WRITE   | result written to the output memory
    // DONE    | frame complete, waiting for the next start
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_COMPUTE, S_WRITE, S_DONE} state_t;

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int SW = PIX_W + 4;
    localparam logic [PIX_W-1:0] MAXP = '1;

    state_t state_q, state_n;
    logic [3:0]        k_q;
    logic [1:0]        wcnt_q;
    logic [XW-1:0]     x_q, cx;
    logic [YW-1:0]     y_q, cy;
    logic [1:0]        mode_q;
    logic [PIX_W-1:0]  win [9];
    logic [PIX_W-1:0]  res_q, res_n, raw;
    logic [ADDR_W-1:0] rd_addr_q, addr_calc;
    logic [RD_LAT-1:0] pv;
    logic [3:0]        pk [RD_LAT];
    logic [3:0]        col, row;
    logic [SW-1:0]     s, nine_c, diff;
    logic              accept, last_pix;
`ifdef BINARIZE_EN
    logic [PIX_W-1:0]  thr_q;
`endif

    assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_pix = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_n = S_FETCH;
            S_FETCH:   if (k_q == 4'd8) state_n = S_WAIT;
            S_WAIT:    if (wcnt_q == 2'(RD_LAT - 1)) state_n = S_COMPUTE;
            S_COMPUTE: state_n = S_WRITE;
            S_WRITE:   state_n = last_pix ? S_DONE : S_FETCH;
            default:   state_n = S_IDLE;
        endcase
    end

    // Window offsets: row-major, row = dy+1, col = dx+1, clamped to the frame.
    always_comb begin
        col = k_q % 4'd3;
        row = k_q / 4'd3;
        case (col)
            4'd0:    cx = (x_q == '0) ? x_q : x_q - 1'b1;
            4'd1:    cx = x_q;
            default: cx = (x_q == XW'(IMG_W - 1)) ? x_q : x_q + 1'b1;
        endcase
        case (row)
            4'd0:    cy = (y_q == '0) ? y_q : y_q - 1'b1;
            4'd1:    cy = y_q;
            default: cy = (y_q == YW'(IMG_H - 1)) ? y_q : y_q + 1'b1;
        endcase
        addr_calc = ADDR_W'(int'(cy) * IMG_W + int'(cx));
    end

    always_comb begin
        s = '0;
        for (int i = 0; i < 9; i++) s = s + SW'(win[i]);
        nine_c = (SW'(win[4]) << 3) + SW'(win[4]);
        diff   = (nine_c >= s) ? nine_c - s : s - nine_c;
        case (mode_q)
            2'd0:    raw = win[4];
            2'd1:    raw = PIX_W'(s / SW'(9));
            2'd2:    raw = (diff > SW'(MAXP)) ? MAXP : PIX_W'(diff);
            default: raw = MAXP - win[4];
        endcase
`ifdef BINARIZE_EN
        res_n = (raw >= thr_q) ? MAXP : '0;
`else
        res_n = raw;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q       <= '0;
            wcnt_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            mode_q    <= '0;
            res_q     <= '0;
            rd_addr_q <= '0;
            pv        <= '0;
            for (int i = 0; i < RD_LAT; i++) pk[i] <= '0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
`ifdef BINARIZE_EN
            thr_q     <= '0;
`endif
        end else begin
            // Read-return pipeline tags each read with its window slot.
            pv[0] <= (state_q == S_FETCH);
            pk[0] <= k_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pk[i] <= pk[i-1];
            end
            if (pv[RD_LAT-1]) win[pk[RD_LAT-1]] <= rd_data;

            if (accept) begin
                mode_q <= mode;
                x_q    <= '0;
                y_q    <= '0;
                k_q    <= '0;
`ifdef BINARIZE_EN
                thr_q  <= thresh;
`endif
            end
            case (state_q)
                S_FETCH: begin
                    k_q       <= (k_q == 4'd8) ? 4'd0 : k_q + 4'd1;
                    wcnt_q    <= '0;
                    rd_addr_q <= addr_calc;
                end
                S_WAIT:    wcnt_q <= wcnt_q + 2'd1;
                S_COMPUTE: res_q  <= res_n;
                S_WRITE: begin
                    if (last_pix) begin
                        x_q <= '0;
                        y_q <= '0;
                    end else if (x_q == XW'(IMG_W - 1)) begin
                        x_q <= '0;
                        y_q <= y_q + 1'b1;
                    end else begin
                        x_q <= x_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_addr = (state_q == S_FETCH) ? addr_calc : rd_addr_q;
    assign wr_en   = (state_q == S_WRITE);
    assign wr_addr = ADDR_W'(int'(y_q) * IMG_W + int'(x_q));
    assign wr_data = res_q;
    assign busy    = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                     (state_q == S_COMPUTE) || (state_q == S_WRITE);
    assign done    = (state_q == S_DONE);
endmodule

// File: tb/tb_frame_filter_engine.sv
// Scoreboard bench: two engines (read latency 1 and 3) on a 4x4 frame, checked against a window-level reference model.
module tb_frame_filter_engine;
    localparam int W = 4, H = 4, N = W * H;

    typedef struct { int addr; int data; } exp_t;

    logic clk = 0, rst = 0, start = 0;
    logic [1:0] mode = 0;
    logic [7:0] thresh = 8'd128;
    logic [7:0] img [N];

    logic [13:0] rd_addr1, wr_addr1, rd_addr3, wr_addr3;
    logic [7:0]  rd_data1, wr_data1, rd_data3, wr_data3;
    logic        wr_en1, busy1, done1, wr_en3, busy3, done3;
    logic [7:0]  r3a, r3b;

    int tests = 0, fails = 0, wcount1 = 0;
    exp_t q1[$], q3[$];

    always #5 clk = ~clk;

    frame_filter_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(14), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
`ifdef BINARIZE_EN
        .thresh(thresh),
`endif
        .rd_addr(rd_addr1), .rd_data(rd_data1), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .busy(busy1), .done(done1));

    frame_filter_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(14), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
`ifdef BINARIZE_EN
        .thresh(thresh),
`endif
        .rd_addr(rd_addr3), .rd_data(rd_data3), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .busy(busy3), .done(done3));

    // Source memories: synchronous reads with one and three cycles of latency.
    always @(posedge clk) begin
        rd_data1 <= img[rd_addr1[3:0]];
        r3a      <= img[rd_addr3[3:0]];
        r3b      <= r3a;
        rd_data3 <= r3b;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    function automatic int ref_pix(input int x, input int y, input int m);
        int s = 0, c, v;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                s += int'(img[clampi(y + dy, H - 1) * W + clampi(x + dx, W - 1)]);
        c = int'(img[y * W + x]);
        case (m)
            0: v = c;
            1: v = s / 9;
            2: begin
                v = 8 * c - (s - c);
                if (v < 0) v = -v;
                if (v > 255) v = 255;
            end
            default: v = 255 - c;
        endcase
`ifdef BINARIZE_EN
        v = (v >= int'(thresh)) ? 255 : 0;
`endif
        return v;
    endfunction

    task automatic push_frame(input int m);
        exp_t e;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                e.addr = y * W + x;
                e.data = ref_pix(x, y, m);
                q1.push_back(e);
                q3.push_back(e);
            end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (wr_en1) begin
            wcount1++;
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL write1: unexpected write addr=%0d data=%0d", wr_addr1, wr_data1);
            end else begin
                e = q1.pop_front();
                if (int'(wr_addr1) != e.addr || int'(wr_data1) != e.data) begin
                    fails++;
                    $display("FAIL write1: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             wr_addr1, wr_data1, e.addr, e.data);
                end
            end
        end
        if (wr_en3) begin
            tests++;
            if (q3.size() == 0) begin
                fails++;
                $display("FAIL write3: unexpected write addr=%0d data=%0d", wr_addr3, wr_data3);
            end else begin
                e = q3.pop_front();
                if (int'(wr_addr3) != e.addr || int'(wr_data3) != e.data) begin
                    fails++;
                    $display("FAIL write3: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             wr_addr3, wr_data3, e.addr, e.data);
                end
            end
        end
    end

    // Runs one frame on both engines; pulses start and scrambles mode while busy.
    task automatic run_frame(input int m);
        int cnt = 0, d1 = -1, d3 = -1;
        push_frame(m);
        @(negedge clk);
        start = 1;
        mode  = 2'(m);
        @(posedge clk);
        #1;
        start = 0;
        mode  = 2'($urandom_range(0, 3));
        chk("busy_after_start", {31'd0, busy1 & busy3}, 1);
        chk("done_drops", {31'd0, done1 | done3}, 0);
        while ((d1 < 0 || d3 < 0) && cnt < 1000) begin
            @(posedge clk);
            cnt++;
            #1;
            if (done1 && d1 < 0) d1 = cnt;
            if (done3 && d3 < 0) d3 = cnt;
            if (cnt == 50) start = 1;
            if (cnt == 52) start = 0;
            if (cnt == 100) mode = 2'($urandom_range(0, 3));
        end
        chk("done_time_lat1", d1, N * 12);
        chk("done_time_lat3", d3, N * 14);
        chk("pending_lat1", q1.size(), 0);
        chk("pending_lat3", q3.size(), 0);
        chk("busy_at_done", {31'd0, busy1 | busy3}, 0);
    endtask

    initial begin
        int base, cnt;
        #1;
        chk("rst_wr_en", {31'd0, wr_en1 | wr_en3}, 0);
        chk("rst_busy", {31'd0, busy1 | busy3}, 0);
        chk("rst_done", {31'd0, done1 | done3}, 0);
        chk("rst_rd_addr", int'(rd_addr1 | rd_addr3), 0);
        chk("rst_wr_addr", int'(wr_addr1 | wr_addr3), 0);
        chk("rst_wr_data", int'(wr_data1 | wr_data3), 0);
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < N; i++) img[i] = 8'(i);
        run_frame(0);
        for (int i = 0; i < N; i++) img[i] = 8'd100;
        run_frame(1);
        for (int i = 0; i < N; i++) img[i] = 8'd0;
        img[1 * W + 1] = 8'd255;
        run_frame(1);
        run_frame(2);
        for (int i = 0; i < N; i++) img[i] = 8'd50;
        run_frame(2);
        for (int i = 0; i < N; i++) img[i] = 8'(i * 10);
        run_frame(3);
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
            if (f % 2 == 1) img[$urandom_range(0, N - 1)] = 8'd255;
            run_frame(int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a frame.
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        push_frame(1);
        base = wcount1;
        @(negedge clk);
        start = 1;
        mode  = 2'd1;
        @(negedge clk);
        start = 0;
        cnt = 0;
        while (wcount1 < base + 5 && cnt < 500) begin
            @(posedge clk);
            cnt++;
        end
        chk("reached_pixel5", cnt < 500 ? 1 : 0, 1);
        #2;
        rst = 0;
        #1;
        q1.delete();
        q3.delete();
        chk("midrst_wr_en", {31'd0, wr_en1 | wr_en3}, 0);
        chk("midrst_busy", {31'd0, busy1 | busy3}, 0);
        chk("midrst_done", {31'd0, done1 | done3}, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (40) @(negedge clk);
        chk("idle_after_rst", {31'd0, busy1 | busy3 | done1 | done3}, 0);
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/frame_filter_engine.md
Name: frame_filter_engine

Overview:
- Parametrised 3x3 neighbourhood filter engine. Replaces the fixed single-mode image processing stage between the input frame block RAM and the output frame memory.
- Reads source pixels through a synchronous-read memory port with configurable latency. Applies a runtime-selectable kernel mode and writes one result per pixel, in raster order, to the output memory port.
- Holds a level `done` that gates output-memory writes and hands the frame to the VGA path.

Parameters:
- IMG_W, 128, frame width in pixels (≥2)
- IMG_H, 128, frame height in pixels (≥2)
- PIX_W, 8, pixel width in bits
- ADDR_W, 14, memory address width; IMG_W*IMG_H ≤ 2^ADDR_W
- RD_LAT, 1, source memory read latency in cycles (1..3)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  frame start request; sampled only in IDLE/DONE
- mode  in  2  kernel select; latched on accepted start
- rd_addr  out  ADDR_W  source memory read address
- rd_data  in  PIX_W  source memory data, valid RD_LAT cycles after rd_addr
- wr_en  out  1  output memory write strobe
- wr_addr  out  ADDR_W  output memory write address
- wr_data  out  PIX_W  filtered pixel
- busy  out  1  high from accepted start until last write
- done  out  1  level; high after last write, until next accepted start

Behaviour:
- Reset: all outputs 0, FSM=IDLE, x=y=0, mode register 0.
- FSM states: IDLE → FETCH → WAIT → COMPUTE → WRITE → (FETCH | DONE).
- Start acceptance: start=1 in IDLE or DONE is accepted. On acceptance: done←0, busy←1, mode latched, x=y=0, go to FETCH. start in any other state is ignored.
- FETCH (9 cycles, k=0..8):
  - rd_addr = cy*IMG_W + cx, where dy=k/3−1 and dx=k%3−1 (row-major window).
  - cx = clamp(x+dx, 0, IMG_W−1) and cy = clamp(y+dy, 0, IMG_H−1). Edges replicate.
  - rd_data is captured into window register w[k] exactly RD_LAT cycles after issue.
- WAIT: RD_LAT cycles, draining the last reads.
- COMPUTE (1 cycle), result per mode (c = w[4], s = sum of all nine):
  - 0 bypass: c.
  - 1 box blur: floor(s/9); s is 4 bits wider than PIX_W.
  - 2 Laplacian: |8*c − (s−c)|, saturated to 2^PIX_W−1.
  - 3 invert: (2^PIX_W−1) − c.
- WRITE (1 cycle): wr_en=1, wr_addr = y*IMG_W + x, wr_data = result. wr_en is 0 in every other state.
- Advance: x increments; at IMG_W−1, x←0 and y increments. After writing (IMG_W−1, IMG_H−1), go to DONE: busy←0, done←1.
- Pixel period: 11+RD_LAT cycles. Frame: IMG_W*IMG_H*(11+RD_LAT) cycles from the accept edge to the done rising edge.
- rd_addr holds its last value outside FETCH.
- mode changes mid-frame have no effect.
- Reset asserted mid-frame: immediate return to IDLE, done=0, no further writes.

Optional Feature:
- Macro BINARIZE_EN.
- Defined: adds port `thresh  in  PIX_W`, sampled with mode on start. wr_data = (result ≥ thresh) ? 2^PIX_W−1 : 0.
- Undefined: no thresh port; wr_data = raw result.

Test Plan:
- Bypass, IMG_W=IMG_H=4, RD_LAT=1, source[i]=i → 16 writes; wr_data[i]=i, wr_addr=0..15 in order; done rises 192 cycles after the accept edge.
- Box blur, constant source of 100 → every wr_data=100. Single 255 at (1,1), all else 0 → wr_data at (0,0)..(2,2) = 28; at (3,3) = 0.
- Laplacian, constant 50 → all 0. Single 255 at (1,1), else 0 → (1,1)=255 (saturated from 2040); (0,1)=255.
- Invert, source[i]=i*10 → wr_data = 255−i*10. RD_LAT=3 → same data; done at 16*14=224 cycles.
- start pulsed while busy and mode changed mid-frame → no restart, results match the latched mode. Second start after done → done drops next cycle, frame reruns.
- rst low at pixel 5 → wr_en, busy, done all 0 immediately. No writes until a new start; that new frame completes correctly.
